// File: rtl/trace_capture.sv
// Oscilloscope trace producer: decimate, edge/auto trigger, capture DEPTH
// samples into a shadow buffer and publish it on a vertical-blanking edge.
module trace_capture #(
   parameter int WIDTH   = 12,
   parameter int DEPTH   = 400,
   parameter int DECIM   = 1,
   parameter int AUTO_TO = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample,
   input  logic             sample_valid,
   input  logic             run,
   input  logic             single,
   input  logic [WIDTH-1:0] trig_level,
   input  logic             trig_slope,
   input  logic             vblnk,
   output logic [WIDTH-1:0] data_out [DEPTH-1:0],
   output logic             busy,
   output logic             auto_trig,
   output logic             frame_updated
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int CW = (AUTO_TO > 0) ? $clog2(AUTO_TO + 1) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);
   localparam logic [CW-1:0] AUTO_LAST =
      CW'((AUTO_TO > 0) ? AUTO_TO - 1 : 0);
   localparam logic [CW-1:0] AUTO_MAX =
      CW'((AUTO_TO > 0) ? AUTO_TO : 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      CAPTURE,
      DONE
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] shadow [DEPTH-1:0];
   logic [WIDTH-1:0] prev_s;
   logic [AW-1:0]    wr_idx;
   logic [DW-1:0]    decim_cnt;
   logic [CW-1:0]    auto_cnt;
   logic             prev_valid;
   logic             auto_flag;
   logic             vblnk_q;
   logic             done_first;

   logic in_acq, accept, rise, fall, edge_hit, auto_hit;
   logic hit, last, publish, arm_entry;

   assign in_acq   = (state == ARM) || (state == CAPTURE);
   assign accept   = in_acq && sample_valid && (decim_cnt == DEC_LAST);
   assign rise     = prev_valid && (prev_s < trig_level)
                     && (sample >= trig_level);
   assign fall     = prev_valid && (prev_s > trig_level)
                     && (sample <= trig_level);
   assign edge_hit = trig_slope ? fall : rise;
   assign auto_hit = (AUTO_TO != 0) && (auto_cnt == AUTO_LAST);
   assign hit      = (state == ARM) && accept && (edge_hit || auto_hit);
   assign last     = (state == CAPTURE) && accept && (wr_idx == LAST_IDX);
   // Edge seen on the very first DONE cycle belongs to the current frame
   assign publish  = (state == DONE) && vblnk && !vblnk_q && !done_first;
   assign arm_entry = (state_n == ARM) && (state != ARM);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (run || single) state_n = ARM;
         ARM:     if (hit) state_n = CAPTURE;
         CAPTURE: if (last) state_n = DONE;
         DONE:    if (publish) state_n = run ? ARM : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx        <= '0;
         decim_cnt     <= '0;
         auto_cnt      <= '0;
         prev_valid    <= 1'b0;
         prev_s        <= '0;
         auto_flag     <= 1'b0;
         vblnk_q       <= 1'b0;
         done_first    <= 1'b0;
         busy          <= 1'b0;
         auto_trig     <= 1'b0;
         frame_updated <= 1'b0;
         for (int i = 0; i < DEPTH; i++) data_out[i] <= '0;
      end else begin
         vblnk_q       <= vblnk;
         frame_updated <= publish;
         busy          <= (state_n != IDLE);
         done_first    <= (state_n == DONE) && (state != DONE);

         if (arm_entry) begin
            decim_cnt  <= '0;
            prev_valid <= 1'b0;
            auto_cnt   <= '0;
         end else if (in_acq && sample_valid) begin
            decim_cnt <= accept ? '0 : decim_cnt + 1'b1;
         end

         if ((state == ARM) && accept) begin
            prev_s     <= sample;
            prev_valid <= 1'b1;
            if (hit) begin
               wr_idx    <= AW'(1);
               auto_flag <= !edge_hit;
            end else if (auto_cnt != AUTO_MAX) begin
               auto_cnt <= auto_cnt + 1'b1;
            end
         end

         if ((state == CAPTURE) && accept)
            wr_idx <= last ? '0 : wr_idx + 1'b1;

         if (publish) begin
            data_out  <= shadow;
            auto_trig <= auto_flag;
         end
      end
   end

   // Shadow storage needs no reset; only written positions are ever published
   always_ff @(posedge clk) begin
      if (hit)
         shadow[0] <= sample;
      else if ((state == CAPTURE) && accept)
         shadow[wr_idx] <= sample;
   end

endmodule
